// File: rtl/ika87ad_pkg.sv
// ----------------------------------------------------------------------------
// ika87ad_pkg
// Shared definitions for the IKA87AD core and its external bus controller.
//   - Bus access type encoding (same encoding as the core's next-bus-access
//     field): IDLE, RD4 (opcode fetch), RD3, WR3.
//   - T-state enumeration for the multiplexed bus cycle FSM.
//   - Helper function classifying read accesses.
// ----------------------------------------------------------------------------
package ika87ad_pkg;

    localparam logic [1:0] BUS_IDLE = 2'b00;
    localparam logic [1:0] BUS_RD4  = 2'b01;
    localparam logic [1:0] BUS_RD3  = 2'b10;
    localparam logic [1:0] BUS_WR3  = 2'b11;

    typedef enum logic [2:0] {
        TS_IDLE = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_T3   = 3'd3,
        TS_T4   = 3'd4
    } tstate_e;

    // True for the two read access types (opcode fetch and plain read).
    function automatic logic is_read(input logic [1:0] acc_type);
        return (acc_type == BUS_RD4) || (acc_type == BUS_RD3);
    endfunction

endpackage

// File: rtl/ika87ad_busctrl.sv
// ----------------------------------------------------------------------------
// ika87ad_busctrl
// External bus controller for the IKA87AD core. On a cycle tick it latches the
// access address, type and write data, then runs one uPD7810-style
// multiplexed bus cycle (T1-T3, or T1-T4 for opcode fetch) and returns the
// sampled read byte.
//
// Ports:
//   i_EMUCLK       emulator master clock (rising edge)
//   i_MRST         synchronous active-high reset
//   i_MCUCLK_PCEN  MCU clock enable; state only advances when 1
//   i_START        cycle tick from the core
//   i_ACC_TYPE     access type (IDLE/RD4/RD3/WR3)
//   i_ADDR         access address
//   i_WRDATA       write byte for WR3
//   i_DI           external AD0-7 input
//   o_A_HI         address bits 15:8
//   o_AD_DO/o_AD_OE  AD0-7 output value / output enable
//   o_ALE          address latch enable (active-high)
//   o_RD_n/o_WR_n/o_M1_n  active-low strobes
//   o_RDDATA       last sampled read byte
//   o_RDDATA_VLD   one-emuclk pulse when o_RDDATA updates
//   o_BUSY         a bus cycle is in progress
//   o_PROTO_ERR    sticky: start arrived outside the final phase of a cycle
// ----------------------------------------------------------------------------
module ika87ad_busctrl
    import ika87ad_pkg::*;
#(
    parameter int PHASES_PER_T = 3
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST,
    input  logic        i_MCUCLK_PCEN,
    input  logic        i_START,
    input  logic [1:0]  i_ACC_TYPE,
    input  logic [15:0] i_ADDR,
    input  logic [7:0]  i_WRDATA,
    input  logic [7:0]  i_DI,
    output logic [7:0]  o_A_HI,
    output logic [7:0]  o_AD_DO,
    output logic        o_AD_OE,
    output logic        o_ALE,
    output logic        o_RD_n,
    output logic        o_WR_n,
    output logic        o_M1_n,
    output logic [7:0]  o_RDDATA,
    output logic        o_RDDATA_VLD,
    output logic        o_BUSY,
    output logic        o_PROTO_ERR
);

    localparam logic [1:0] LAST_PH = 2'(PHASES_PER_T - 1);

    tstate_e     state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  type_q, type_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [7:0]  a_hi_q, a_hi_d;
    logic [7:0]  ad_do_q, ad_do_d;
    logic        ad_oe_q, ad_oe_d;
    logic        ale_q, ale_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        m1_n_q, m1_n_d;
    logic [7:0]  rddata_q, rddata_d;
    logic        vld_q, vld_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic        final_s;
    logic        sample_s;
    logic        wr_cyc_s;

    // Next-state logic: FSM sequencing, error flag, read sampling and the
    // pin values that correspond to the state being entered.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        type_d   = type_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rddata_d = rddata_q;

        // Last phase of the last T-state; the only point a new start is legal.
        final_s  = (phase_q == LAST_PH) &&
                   ((state_q == TS_T4) ||
                    ((state_q == TS_T3) && (type_q != BUS_RD4)));
        // Data is captured when leaving T2, aligned with the core data latch.
        sample_s = i_MCUCLK_PCEN && (state_q == TS_T2) &&
                   (phase_q == LAST_PH) && is_read(type_q);
        vld_d    = sample_s;

        if (sample_s) begin
            rddata_d = i_DI;
        end else begin
            rddata_d = rddata_q;
        end

        if (i_MCUCLK_PCEN) begin
            if (i_START && (state_q != TS_IDLE) && !final_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end

            if (i_START && ((state_q == TS_IDLE) || final_s)) begin
                phase_d = 2'd0;
                if (i_ACC_TYPE != BUS_IDLE) begin
                    state_d = TS_T1;
                    type_d  = i_ACC_TYPE;
                    addr_d  = i_ADDR;
                    wdata_d = i_WRDATA;
                end else begin
                    state_d = TS_IDLE;
                end
            end else if (state_q == TS_IDLE) begin
                phase_d = 2'd0;
            end else if (phase_q == LAST_PH) begin
                phase_d = 2'd0;
                case (state_q)
                    TS_T1:   state_d = TS_T2;
                    TS_T2:   state_d = TS_T3;
                    TS_T3:   state_d = (type_q == BUS_RD4) ? TS_T4 : TS_IDLE;
                    TS_T4:   state_d = TS_IDLE;
                    default: state_d = TS_IDLE;
                endcase
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end else begin
            err_d = err_q;
        end

        // Pin values decoded from the state being entered, so they change on
        // the same edge that advances the phase.
        wr_cyc_s = (type_d == BUS_WR3);
        busy_d   = (state_d != TS_IDLE);
        a_hi_d   = busy_d ? addr_d[15:8] : a_hi_q;

        if (state_d == TS_T1) begin
            ad_do_d = addr_d[7:0];
        end else if (wr_cyc_s && ((state_d == TS_T2) || (state_d == TS_T3))) begin
            ad_do_d = wdata_d;
        end else begin
            ad_do_d = ad_do_q;
        end

        ad_oe_d = (state_d == TS_T1) ||
                  (wr_cyc_s && ((state_d == TS_T2) || (state_d == TS_T3)));
        ale_d   = (state_d == TS_T1) && (phase_d < LAST_PH);
        rd_n_d  = !(is_read(type_d) && ((state_d == TS_T2) || (state_d == TS_T3)));
        wr_n_d  = !(wr_cyc_s &&
                    (((state_d == TS_T2) && (phase_d != 2'd0)) ||
                     ((state_d == TS_T3) && (phase_d < LAST_PH))));
        m1_n_d  = !(busy_d && (type_d == BUS_RD4));
    end

    // State and output registers; the valid pulse clears on every clock so it
    // lasts exactly one emuclk even under a sustained clock enable.
    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            state_q  <= TS_IDLE;
            phase_q  <= 2'd0;
            type_q   <= BUS_IDLE;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            a_hi_q   <= 8'hFF;
            ad_do_q  <= 8'h00;
            ad_oe_q  <= 1'b0;
            ale_q    <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            m1_n_q   <= 1'b1;
            rddata_q <= 8'h00;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (i_MCUCLK_PCEN) begin
                state_q  <= state_d;
                phase_q  <= phase_d;
                type_q   <= type_d;
                addr_q   <= addr_d;
                wdata_q  <= wdata_d;
                a_hi_q   <= a_hi_d;
                ad_do_q  <= ad_do_d;
                ad_oe_q  <= ad_oe_d;
                ale_q    <= ale_d;
                rd_n_q   <= rd_n_d;
                wr_n_q   <= wr_n_d;
                m1_n_q   <= m1_n_d;
                rddata_q <= rddata_d;
                busy_q   <= busy_d;
                err_q    <= err_d;
            end
        end
    end

    assign o_A_HI       = a_hi_q;
    assign o_AD_DO      = ad_do_q;
    assign o_AD_OE      = ad_oe_q;
    assign o_ALE        = ale_q;
    assign o_RD_n       = rd_n_q;
    assign o_WR_n       = wr_n_q;
    assign o_M1_n       = m1_n_q;
    assign o_RDDATA     = rddata_q;
    assign o_RDDATA_VLD = vld_q;
    assign o_BUSY       = busy_q;
    assign o_PROTO_ERR  = err_q;

endmodule

// File: tb/tb_ika87ad_busctrl.sv
// ----------------------------------------------------------------------------
// tb_ika87ad_busctrl
// Self-checking bench for ika87ad_busctrl. A behavioural model tracks each bus
// cycle as a tick position (1..12 or 1..9) and derives every pin from it.
// ----------------------------------------------------------------------------
module tb_ika87ad_busctrl;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_RD4  = 2'b01;
    localparam logic [1:0] T_RD3  = 2'b10;
    localparam logic [1:0] T_WR3  = 2'b11;

    logic        clk = 1'b0;
    logic        mrst = 1'b1;
    logic        pcen = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  acc_type = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wrdata = 8'h00;
    logic [7:0]  di = 8'h00;
    logic [7:0]  a_hi, ad_do, rddata;
    logic        ad_oe, ale, rd_n, wr_n, m1_n, vld, busy, perr;

    int tests_run = 0;
    int tests_failed = 0;

    // model state: position within the running cycle (0 = idle)
    int          m_p = 0;
    logic [1:0]  m_type = 2'b00;
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_wd = 8'h00;
    logic [7:0]  m_ahi = 8'hFF;
    logic [7:0]  m_ado = 8'h00;
    logic [7:0]  m_rd = 8'h00;
    logic        m_vld = 1'b0;
    logic        m_err = 1'b0;

    // observed strobe counters for the directed cycles
    int cnt_ale, cnt_rd, cnt_wr, cnt_m1, cnt_busy;

    ika87ad_busctrl #(.PHASES_PER_T(3)) dut (
        .i_EMUCLK     (clk),
        .i_MRST       (mrst),
        .i_MCUCLK_PCEN(pcen),
        .i_START      (start),
        .i_ACC_TYPE   (acc_type),
        .i_ADDR       (addr),
        .i_WRDATA     (wrdata),
        .i_DI         (di),
        .o_A_HI       (a_hi),
        .o_AD_DO      (ad_do),
        .o_AD_OE      (ad_oe),
        .o_ALE        (ale),
        .o_RD_n       (rd_n),
        .o_WR_n       (wr_n),
        .o_M1_n       (m1_n),
        .o_RDDATA     (rddata),
        .o_RDDATA_VLD (vld),
        .o_BUSY       (busy),
        .o_PROTO_ERR  (perr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_len();
        return (m_type == T_RD4) ? 12 : 9;
    endfunction

    // advance the model by one emuclk edge using the applied inputs
    task automatic model_edge(input bit pc, input bit st, input logic [1:0] ty,
                              input logic [15:0] ad, input logic [7:0] wd,
                              input logic [7:0] dv, input bit rs);
        int len;
        bit boundary;
        if (rs) begin
            m_p = 0; m_type = T_IDLE; m_ahi = 8'hFF; m_ado = 8'h00;
            m_rd = 8'h00; m_vld = 1'b0; m_err = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (pc) begin
                len = m_len();
                // capture at the end of T2 (sixth tick) for reads
                if (m_p == 6 && m_type != T_WR3) begin
                    m_rd = dv;
                    m_vld = 1'b1;
                end
                boundary = (m_p == 0) || (m_p == len);
                if (st && !boundary) m_err = 1'b1;
                if (st && boundary && ty != T_IDLE) begin
                    m_p = 1; m_type = ty; m_addr = ad; m_wd = wd;
                end else if (boundary) begin
                    m_p = 0;
                end else begin
                    m_p++;
                end
                if (m_p > 0) begin
                    m_ahi = m_addr[15:8];
                    if ((m_p - 1) / 3 == 0) m_ado = m_addr[7:0];
                    else if (m_type == T_WR3 && (m_p - 1) / 3 <= 2) m_ado = m_wd;
                end
            end
        end
    endtask

    task automatic compare_all();
        int ts, ph;
        bit act;
        act = (m_p > 0);
        ts = act ? (m_p - 1) / 3 : 0;
        ph = act ? (m_p - 1) % 3 : 0;
        check_val("a_hi",   16'(a_hi),   16'(m_ahi));
        check_val("ad_do",  16'(ad_do),  16'(m_ado));
        check_val("ad_oe",  16'(ad_oe),  16'(act && (ts == 0 || (m_type == T_WR3 && ts <= 2))));
        check_val("ale",    16'(ale),    16'(act && ts == 0 && ph < 2));
        check_val("rd_n",   16'(rd_n),   16'(!(act && m_type != T_WR3 && (ts == 1 || ts == 2))));
        check_val("wr_n",   16'(wr_n),   16'(!(act && m_type == T_WR3 && m_p >= 5 && m_p <= 8)));
        check_val("m1_n",   16'(m1_n),   16'(!(act && m_type == T_RD4)));
        check_val("rddata", 16'(rddata), 16'(m_rd));
        check_val("vld",    16'(vld),    16'(m_vld));
        check_val("busy",   16'(busy),   16'(act));
        check_val("perr",   16'(perr),   16'(m_err));
    endtask

    // apply inputs, clock one edge, then check at the falling edge
    task automatic step(input bit pc, input bit st, input logic [1:0] ty,
                        input logic [15:0] ad, input logic [7:0] wd,
                        input logic [7:0] dv, input bit rs);
        pcen = pc; start = st; acc_type = ty; addr = ad; wrdata = wd; di = dv; mrst = rs;
        @(posedge clk);
        model_edge(pc, st, ty, ad, wd, dv, rs);
        @(negedge clk);
        compare_all();
        if (!ale)  cnt_ale  = cnt_ale;
        if (ale)   cnt_ale++;
        if (!rd_n) cnt_rd++;
        if (!wr_n) cnt_wr++;
        if (!m1_n) cnt_m1++;
        if (busy)  cnt_busy++;
    endtask

    task automatic clr_cnt();
        cnt_ale = 0; cnt_rd = 0; cnt_wr = 0; cnt_m1 = 0; cnt_busy = 0;
    endtask

    // idle tick with the read data set to 'dv' only at the sampling point
    task automatic run_ticks(input int n, input logic [7:0] dv);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, T_IDLE, 16'(($urandom)), 8'($urandom),
                 (m_p == 6) ? dv : 8'($urandom), 1'b0);
        end
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 1'b0, T_IDLE, 16'h0000, 8'h00, 8'h00, 1'b1);
        check_val("reset_a_hi", 16'(a_hi), 16'h00FF);
        check_val("reset_busy", 16'(busy), 16'h0000);
        run_ticks(2, 8'h00);

        // RD4 at 0x1234, 0xA5 on the bus at the end of T2
        clr_cnt();
        step(1'b1, 1'b1, T_RD4, 16'h1234, 8'h77, 8'h00, 1'b0);
        check_val("rd4_a_hi", 16'(a_hi), 16'h0012);
        check_val("rd4_ad_do_t1", 16'(ad_do), 16'h0034);
        run_ticks(11, 8'hA5);
        step(1'b1, 1'b0, T_IDLE, 16'h0000, 8'h00, 8'h00, 1'b0);
        check_val("rd4_ale_ticks", 16'(cnt_ale), 16'd2);
        check_val("rd4_rd_ticks", 16'(cnt_rd), 16'd6);
        check_val("rd4_m1_ticks", 16'(cnt_m1), 16'd12);
        check_val("rd4_busy_ticks", 16'(cnt_busy), 16'd12);
        check_val("rd4_rddata", 16'(rddata), 16'h00A5);

        // WR3 to 0xFF00 with 0x5A
        clr_cnt();
        step(1'b1, 1'b1, T_WR3, 16'hFF00, 8'h5A, 8'h00, 1'b0);
        check_val("wr3_ad_do_t1", 16'(ad_do), 16'h0000);
        run_ticks(4, 8'h00);
        check_val("wr3_ad_do_t2", 16'(ad_do), 16'h005A);
        run_ticks(5, 8'h00);
        check_val("wr3_wr_ticks", 16'(cnt_wr), 16'd4);
        check_val("wr3_m1_ticks", 16'(cnt_m1), 16'd0);
        check_val("wr3_busy_ticks", 16'(cnt_busy), 16'd9);

        // back-to-back RD3 then WR3, second start on the final tick
        step(1'b1, 1'b1, T_RD3, 16'h4321, 8'h00, 8'h00, 1'b0);
        run_ticks(8, 8'h3C);
        step(1'b1, 1'b1, T_WR3, 16'h8765, 8'hC3, 8'h00, 1'b0);
        check_val("b2b_ale", 16'(ale), 16'h0001);
        check_val("b2b_busy", 16'(busy), 16'h0001);
        check_val("b2b_rddata", 16'(rddata), 16'h003C);
        run_ticks(9, 8'h00);

        // start in T2 phase 1 of a read: ignored, error flag set
        step(1'b1, 1'b1, T_RD3, 16'hABCD, 8'h00, 8'h00, 1'b0);
        run_ticks(4, 8'h99);
        step(1'b1, 1'b1, T_WR3, 16'h1111, 8'h22, 8'h00, 1'b0);
        check_val("midstart_err", 16'(perr), 16'h0001);
        run_ticks(8, 8'h99);
        check_val("midstart_rddata", 16'(rddata), 16'h0099);
        check_val("midstart_err_hold", 16'(perr), 16'h0001);

        // reset in T2 of a read, with a start on the same edge
        step(1'b1, 1'b1, T_RD4, 16'h5555, 8'h00, 8'h00, 1'b0);
        run_ticks(4, 8'h00);
        step(1'b0, 1'b1, T_RD3, 16'h6666, 8'h00, 8'h00, 1'b1);
        check_val("midrst_busy", 16'(busy), 16'h0000);
        check_val("midrst_err", 16'(perr), 16'h0000);
        check_val("midrst_a_hi", 16'(a_hi), 16'h00FF);

        // throttled enable (1 in 4) over a full RD4
        for (int k = 0; k < 60; k++) begin
            step((k % 4) == 0, (k == 0), T_RD4, 16'h2468, 8'h00,
                 (m_p == 6) ? 8'h5C : 8'($urandom), 1'b0);
        end
        check_val("throttle_rddata", 16'(rddata), 16'h005C);

        // randomized traffic with varying enable density
        for (int blk = 0; blk < 40; blk++) begin
            int dens;
            dens = $urandom_range(0, 2);
            for (int k = 0; k < 60; k++) begin
                bit pc, st, rs;
                logic [1:0] ty;
                pc = (dens == 0) ? 1'b1 : ($urandom_range(0, dens * 2) == 0);
                if (m_p == 0 || m_p == m_len())
                    st = ($urandom_range(0, 1) == 1);
                else
                    st = ($urandom_range(0, 39) == 0);
                rs = ($urandom_range(0, 299) == 0);
                ty = 2'($urandom_range(0, 3));
                step(pc, st, ty, 16'($urandom), 8'($urandom), 8'($urandom), rs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
